spi_reg_ctrl: RTL and testbench
===============================

// Module: spi_reg_ctrl
// PURPOSE
//  sys_clk-domain command sequencer for the SPI slave byte engine. Synchronises ss and the
//  byte-ready strobe, then decodes the first byte of each frame as a command (R/W + address).
//  Runs auto-incrementing write or read bursts against a local bank of 8-bit registers.
//  Supplies read data to the SPI engine as a pre-load byte plus a one-cycle load pulse.
// PARAMETERS
//  NREGS       8      number of 8-bit registers, 1..127; addresses 0..NREGS-1
//  RESET_VAL   8'h00  reset value of every register
//  SYNC_STAGES 2      flop stages on ss and spi_byte_rdy, >=2
// PORTS
//  sys_clk      in   1          system clock, all logic on rising edge
//  rst_n        in   1          asynchronous, active-low reset
//  ss           in   1          slave select from pad, active-high (frame open while 1)
//  spi_byte_rdy in   1          byte-complete level from SPI engine, asynchronous to sys_clk
//  spi_rx_byte  in   8          received byte; stable while spi_byte_rdy=1
//  spi_tx_byte  out  8          next byte for SPI engine to shift out
//  spi_tx_load  out  1          1-cycle pulse: engine copies spi_tx_byte into its shifter
//  reg_q        out  8*NREGS    flattened register bank; reg i = reg_q[8*i+7:8*i]
//  reg_wr_stb   out  1          1-cycle pulse on every committed SPI write
//  reg_wr_addr  out  7          address of that write, valid with reg_wr_stb
//  busy         out  1          1 whenever FSM is not IDLE
//  err          out  1          sticky: frame addressed >=NREGS; cleared at next frame start
// BEHAVIOUR
//  Reset (rst_n=0, async): FSM=IDLE; all regs=RESET_VAL; spi_tx_byte=8'h00; spi_tx_load=0;
//   reg_wr_stb=0; reg_wr_addr=0; busy=0; err=0; sync flops=0. Applies mid-frame too.
//  Sync: ss_s, rdy_s = SYNC_STAGES-flop versions. byte_evt = 1-cycle rising edge of rdy_s.
//   ss_rise/ss_fall = edges of ss_s. spi_rx_byte is sampled only on the byte_evt cycle.
//  Command byte: bit7=1 write, 0 read; bits[6:0] = start address.
//  FSM states: IDLE, CMD, WR, RD, ERR.
//   IDLE -> CMD on ss_rise; err cleared that cycle.
//   CMD, on byte_evt:
//    - addr>=NREGS -> ERR; err=1.
//    - write cmd -> WR; ptr=addr.
//    - read cmd -> RD; ptr=addr+1 (wrapped); next cycle spi_tx_byte=reg[addr], spi_tx_load=1.
//   WR, on byte_evt: reg[ptr]<=spi_rx_byte, reg_wr_stb=1 and reg_wr_addr=ptr next cycle,
//    ptr<=ptr+1, wrapping NREGS-1 -> 0.
//   RD, on byte_evt: spi_tx_byte<=reg[ptr], spi_tx_load=1 next cycle, ptr<=ptr+1 (wrap).
//    Incoming byte is discarded.
//   ERR: byte_evt ignored; no writes; any load pulse carries spi_tx_byte=8'hFF.
//   Any state except IDLE -> IDLE on ss_fall. ss_fall wins over a same-cycle byte_evt;
//    that byte is discarded.
//  Latency:
//   - byte_evt is SYNC_STAGES+1 sys_clk after spi_byte_rdy rises.
//   - Register update, reg_wr_stb and spi_tx_load are exactly 1 cycle after byte_evt.
//  Read data is sampled from reg at load time, including a value written earlier in the frame.
//  A frame with only a command byte performs no write; busy drops on the cycle after ss_fall.
//  spi_byte_rdy held high across frames: no byte_evt until it falls and rises again.
//  Outputs registered; no combinational path from inputs to outputs.
// STRUCTURE
//  spi_pkg: FSM state localparams (IDLE/CMD/WR/RD/ERR), CMD_WR_BIT=7, ERR_FILL=8'hFF, ADDR_W=7.
//  Sub-module spi_sync_edge: parameterised N-flop synchroniser plus rise/fall pulse.
//   Instantiated twice (ss, spi_byte_rdy).
//  Register bank, pointer and FSM live in this module.
// TESTING
//  T1 reset: rst_n=0 mid-burst -> all reg_q=RESET_VAL, busy=0, err=0, spi_tx_load=0.
//  T2 write burst: ss=1; bytes 8'h82,8'hA5,8'h3C ->
//   reg2=A5, reg3=3C; two reg_wr_stb pulses, addr 2 then 3.
//  T3 wrap + read: write 8'h87,11,22 (NREGS=8); then read 8'h07 ->
//   reg7=11, reg0=22; tx loads 11 then 22.
//  T4 error: command 8'h8A (NREGS=8) -> err=1; following bytes change no reg;
//   loads carry FF; next frame clears err.
//  T5 race: ss falls on same cycle as byte_evt in WR -> no write, FSM=IDLE next cycle.
//  T6 latency: check byte_evt at +3 cycles and spi_tx_load at +4 after spi_byte_rdy rise
//   (SYNC_STAGES=2).

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register controller: FSM states and
// command-byte field constants.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WR,
        ST_RD,
        ST_ERR
    } state_t;

    localparam int         CMD_WR_BIT = 7;
    localparam logic [7:0] ERR_FILL   = 8'hFF;
    localparam int         ADDR_W     = 7;

endpackage

// File: rtl/spi_sync_edge.sv
// N-flop synchroniser for an asynchronous level, with registered one-cycle
// rise and fall pulses derived from the synchronised level.
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sh;
    logic              prev;

    assign level = sh[STAGES-1];

    // Shift the async input through the chain, then register its edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh   <= '0;
            prev <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            sh   <= {sh[STAGES-2:0], d};
            prev <= sh[STAGES-1];
            rise <= sh[STAGES-1] & ~prev;
            fall <= ~sh[STAGES-1] & prev;
        end
    end

endmodule

// File: rtl/spi_reg_ctrl.sv
// Command sequencer for the SPI slave byte engine: decodes the first byte of
// each frame as R/W + start address and runs auto-incrementing bursts against
// a local bank of 8-bit registers.
module spi_reg_ctrl
    import spi_pkg::*;
#(
    parameter int         NREGS       = 8,
    parameter logic [7:0] RESET_VAL   = 8'h00,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                 sys_clk,
    input  logic                 rst_n,
    input  logic                 ss,
    input  logic                 spi_byte_rdy,
    input  logic [7:0]           spi_rx_byte,
    output logic [7:0]           spi_tx_byte,
    output logic                 spi_tx_load,
    output logic [8*NREGS-1:0]   reg_q,
    output logic                 reg_wr_stb,
    output logic [ADDR_W-1:0]    reg_wr_addr,
    output logic                 busy,
    output logic                 err
);

    localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [7:0]        regs [NREGS];

    logic ss_level, ss_rise, ss_fall;
    logic rdy_level, byte_evt, rdy_fall;
    logic unused_sync;

    logic [ADDR_W-1:0] cmd_addr;
    logic              cmd_bad;

    assign unused_sync = &{1'b0, ss_level, rdy_level, rdy_fall};

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_ss_sync (
        .clk   (sys_clk),
        .rst_n (rst_n),
        .d     (ss),
        .level (ss_level),
        .rise  (ss_rise),
        .fall  (ss_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_rdy_sync (
        .clk   (sys_clk),
        .rst_n (rst_n),
        .d     (spi_byte_rdy),
        .level (rdy_level),
        .rise  (byte_evt),
        .fall  (rdy_fall)
    );

    assign cmd_addr = spi_rx_byte[ADDR_W-1:0];
    assign cmd_bad  = (32'(cmd_addr) >= NREGS);

    // Burst pointer advance, wrapping from the last register back to zero
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return (a == ADDR_W'(NREGS - 1)) ? '0 : a + 1'b1;
    endfunction

    // Flatten the register bank onto the output bus
    for (genvar g = 0; g < NREGS; g++) begin : g_flat
        assign reg_q[8*g +: 8] = regs[g];
    end

    // Frame FSM, burst pointer, register bank and all registered outputs
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            spi_tx_byte <= 8'h00;
            spi_tx_load <= 1'b0;
            reg_wr_stb  <= 1'b0;
            reg_wr_addr <= '0;
            busy        <= 1'b0;
            err         <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= RESET_VAL;
            end
        end else begin
            spi_tx_load <= 1'b0;
            reg_wr_stb  <= 1'b0;
            if (ss_fall && state != ST_IDLE) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (ss_rise) begin
                            state <= ST_CMD;
                            busy  <= 1'b1;
                            err   <= 1'b0;
                        end
                    end
                    ST_CMD: begin
                        if (byte_evt) begin
                            if (cmd_bad) begin
                                state       <= ST_ERR;
                                err         <= 1'b1;
                                spi_tx_byte <= ERR_FILL;
                                spi_tx_load <= 1'b1;
                            end else if (spi_rx_byte[CMD_WR_BIT]) begin
                                state <= ST_WR;
                                ptr   <= cmd_addr;
                            end else begin
                                state       <= ST_RD;
                                ptr         <= next_addr(cmd_addr);
                                spi_tx_byte <= regs[cmd_addr[IDX_W-1:0]];
                                spi_tx_load <= 1'b1;
                            end
                        end
                    end
                    ST_WR: begin
                        if (byte_evt) begin
                            regs[ptr[IDX_W-1:0]] <= spi_rx_byte;
                            reg_wr_stb           <= 1'b1;
                            reg_wr_addr          <= ptr;
                            ptr                  <= next_addr(ptr);
                        end
                    end
                    ST_RD: begin
                        if (byte_evt) begin
                            spi_tx_byte <= regs[ptr[IDX_W-1:0]];
                            spi_tx_load <= 1'b1;
                            ptr         <= next_addr(ptr);
                        end
                    end
                    ST_ERR: begin
                        if (byte_evt) begin
                            spi_tx_byte <= ERR_FILL;
                            spi_tx_load <= 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench for spi_reg_ctrl: directed frames plus random frames,
// scored against a frame-level model of the register bank.
module tb_spi_reg_ctrl;

    logic        sys_clk;
    logic        rst_n;
    logic        ss;
    logic        spi_byte_rdy;
    logic [7:0]  spi_rx_byte;
    logic [7:0]  spi_tx_byte;
    logic        spi_tx_load;
    logic [63:0] reg_q;
    logic        reg_wr_stb;
    logic [6:0]  reg_wr_addr;
    logic        busy;
    logic        err;

    int total = 0;
    int bad   = 0;

    logic [7:0] mdl [8];
    bit         mdl_err;
    logic [7:0] frame_q [$];
    logic [6:0] exp_wa [$];
    logic [7:0] exp_wd [$];
    logic [7:0] exp_ld [$];
    logic [6:0] wr_addr_q [$];
    logic [7:0] wr_data_q [$];
    logic [7:0] load_q [$];

    spi_reg_ctrl #(.NREGS(8), .RESET_VAL(8'h00), .SYNC_STAGES(2)) dut (
        .sys_clk      (sys_clk),
        .rst_n        (rst_n),
        .ss           (ss),
        .spi_byte_rdy (spi_byte_rdy),
        .spi_rx_byte  (spi_rx_byte),
        .spi_tx_byte  (spi_tx_byte),
        .spi_tx_load  (spi_tx_load),
        .reg_q        (reg_q),
        .reg_wr_stb   (reg_wr_stb),
        .reg_wr_addr  (reg_wr_addr),
        .busy         (busy),
        .err          (err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Record every write strobe and load pulse, sampled mid-cycle
    always @(negedge sys_clk) begin
        if (reg_wr_stb) begin
            wr_addr_q.push_back(reg_wr_addr);
            wr_data_q.push_back(reg_q[8*int'(reg_wr_addr) +: 8]);
        end
        if (spi_tx_load) load_q.push_back(spi_tx_byte);
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic clear_monitor();
        wr_addr_q.delete();
        wr_data_q.delete();
        load_q.delete();
    endtask

    // Frame-level model: first byte is the command, the rest burst with wrap
    task automatic model_frame();
        logic [7:0] cmd;
        int         a;
        int         p;
        exp_wa.delete();
        exp_wd.delete();
        exp_ld.delete();
        mdl_err = 1'b0;
        if (frame_q.size() == 0) return;
        cmd = frame_q[0];
        a   = int'(cmd[6:0]);
        if (a >= 8) begin
            mdl_err = 1'b1;
            foreach (frame_q[i]) exp_ld.push_back(8'hFF);
        end else if (cmd[7]) begin
            p = a;
            for (int i = 1; i < frame_q.size(); i++) begin
                mdl[p] = frame_q[i];
                exp_wa.push_back(7'(p));
                exp_wd.push_back(frame_q[i]);
                p = (p + 1) % 8;
            end
        end else begin
            p = a;
            foreach (frame_q[i]) begin
                exp_ld.push_back(mdl[p]);
                p = (p + 1) % 8;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge sys_clk); #1;
        spi_rx_byte  = b;
        spi_byte_rdy = 1'b1;
        repeat (6) @(posedge sys_clk);
        #1 spi_byte_rdy = 1'b0;
        repeat (4) @(posedge sys_clk);
    endtask

    task automatic open_frame();
        @(posedge sys_clk); #1;
        ss = 1'b1;
        repeat (4) @(posedge sys_clk);
    endtask

    task automatic close_frame();
        @(posedge sys_clk); #1;
        ss = 1'b0;
        repeat (6) @(posedge sys_clk);
        #1;
    endtask

    task automatic run_frame();
        clear_monitor();
        open_frame();
        foreach (frame_q[i]) send_byte(frame_q[i]);
        close_frame();
    endtask

    // Compare observed strobes, loads, bank and flags with the frame model
    task automatic score_frame(input string name);
        model_frame();
        total++;
        if (wr_addr_q.size() != exp_wa.size()) begin
            bad++;
            $display("[TB] FAIL %s wr_count: got %0d expected %0d", name, wr_addr_q.size(), exp_wa.size());
        end
        for (int i = 0; i < exp_wa.size() && i < wr_addr_q.size(); i++) begin
            total++;
            if (wr_addr_q[i] !== exp_wa[i] || wr_data_q[i] !== exp_wd[i]) begin
                bad++;
                $display("[TB] FAIL %s wr[%0d]: got a=%0d d=%h expected a=%0d d=%h",
                         name, i, wr_addr_q[i], wr_data_q[i], exp_wa[i], exp_wd[i]);
            end
        end
        total++;
        if (load_q.size() != exp_ld.size()) begin
            bad++;
            $display("[TB] FAIL %s load_count: got %0d expected %0d", name, load_q.size(), exp_ld.size());
        end
        for (int i = 0; i < exp_ld.size() && i < load_q.size(); i++) begin
            total++;
            if (load_q[i] !== exp_ld[i]) begin
                bad++;
                $display("[TB] FAIL %s load[%0d]: got %h expected %h", name, i, load_q[i], exp_ld[i]);
            end
        end
        for (int r = 0; r < 8; r++) begin
            total++;
            if (reg_q[8*r +: 8] !== mdl[r]) begin
                bad++;
                $display("[TB] FAIL %s reg%0d: got %h expected %h", name, r, reg_q[8*r +: 8], mdl[r]);
            end
        end
        total++;
        if (err !== mdl_err || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s flags: got err=%b busy=%b expected err=%b busy=0", name, err, busy, mdl_err);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ss = 1'b0; spi_byte_rdy = 1'b0; spi_rx_byte = 8'h00;
        for (int r = 0; r < 8; r++) mdl[r] = 8'h00;
        repeat (3) @(posedge sys_clk);
        #1;
        total++;
        if (reg_q !== 64'h0 || busy !== 1'b0 || err !== 1'b0 || spi_tx_load !== 1'b0
            || spi_tx_byte !== 8'h00 || reg_wr_stb !== 1'b0 || reg_wr_addr !== 7'd0) begin
            bad++;
            $display("[TB] FAIL reset: got regs=%h busy=%b err=%b load=%b tx=%h stb=%b wa=%0d expected all zero",
                     reg_q, busy, err, spi_tx_load, spi_tx_byte, reg_wr_stb, reg_wr_addr);
        end
        rst_n = 1'b1;
        repeat (2) @(posedge sys_clk);
    endtask

    task automatic test_write_burst();
        frame_q = '{8'h82, 8'hA5, 8'h3C};
        run_frame();
        score_frame("write_burst");
        total++;
        if (reg_q[23:16] !== 8'hA5 || reg_q[31:24] !== 8'h3C) begin
            bad++;
            $display("[TB] FAIL write_burst_const: got reg2=%h reg3=%h expected A5 3C", reg_q[23:16], reg_q[31:24]);
        end
    endtask

    task automatic test_wrap_read();
        frame_q = '{8'h87, 8'h11, 8'h22};
        run_frame();
        score_frame("wrap_write");
        frame_q = '{8'h07, 8'h00, 8'h00};
        run_frame();
        score_frame("wrap_read");
        total++;
        if (load_q.size() < 2 || load_q[0] !== 8'h11 || load_q[1] !== 8'h22) begin
            bad++;
            $display("[TB] FAIL wrap_read_const: got %0d loads first=%h expected 11 then 22",
                     load_q.size(), (load_q.size() > 0) ? load_q[0] : 8'hxx);
        end
    endtask

    task automatic test_error();
        frame_q = '{8'h8A, 8'h55, 8'h66};
        run_frame();
        score_frame("error");
        open_frame();
        repeat (2) @(posedge sys_clk);
        #1;
        total++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL error_clear: got err=%b busy=%b expected err=0 busy=1", err, busy);
        end
        close_frame();
    endtask

    task automatic test_race();
        logic [7:0] keep;
        keep = mdl[1];
        clear_monitor();
        open_frame();
        send_byte(8'h81);
        @(posedge sys_clk); #1;
        spi_rx_byte  = 8'h5A;
        spi_byte_rdy = 1'b1;
        ss           = 1'b0;
        repeat (4) @(posedge sys_clk);
        #1;
        total++;
        if (busy !== 1'b0 || reg_wr_stb !== 1'b0) begin
            bad++;
            $display("[TB] FAIL race_idle: got busy=%b stb=%b expected 0 0", busy, reg_wr_stb);
        end
        spi_byte_rdy = 1'b0;
        repeat (4) @(posedge sys_clk);
        #1;
        total++;
        if (wr_addr_q.size() != 0 || reg_q[15:8] !== keep) begin
            bad++;
            $display("[TB] FAIL race_nowrite: got %0d writes reg1=%h expected 0 writes reg1=%h",
                     wr_addr_q.size(), reg_q[15:8], keep);
        end
    endtask

    // Count cycles from a byte-ready rise to the resulting output pulse
    task automatic test_latency();
        logic [7:0] v;
        int         hit;
        v = 8'($urandom);
        open_frame();
        send_byte(8'h84);
        @(posedge sys_clk); #1;
        spi_rx_byte = v; spi_byte_rdy = 1'b1;
        hit = 0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge sys_clk); #1;
            if (reg_wr_stb && hit == 0) hit = k;
        end
        mdl[4] = v;
        total++;
        if (hit != 4) begin
            bad++;
            $display("[TB] FAIL latency_wr: got stb at +%0d expected +4", hit);
        end
        spi_byte_rdy = 1'b0;
        repeat (4) @(posedge sys_clk);
        close_frame();
        open_frame();
        @(posedge sys_clk); #1;
        spi_rx_byte = 8'h04; spi_byte_rdy = 1'b1;
        hit = 0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge sys_clk); #1;
            if (spi_tx_load && hit == 0) begin
                hit = k;
                total++;
                if (spi_tx_byte !== mdl[4]) begin
                    bad++;
                    $display("[TB] FAIL latency_rd_data: got %h expected %h", spi_tx_byte, mdl[4]);
                end
            end
        end
        total++;
        if (hit != 4) begin
            bad++;
            $display("[TB] FAIL latency_rd: got load at +%0d expected +4", hit);
        end
        spi_byte_rdy = 1'b0;
        repeat (4) @(posedge sys_clk);
        close_frame();
    endtask

    task automatic test_random();
        int n;
        for (int f = 0; f < 30; f++) begin
            frame_q.delete();
            n = $urandom_range(1, 6);
            frame_q.push_back({1'($urandom), 7'($urandom_range(0, 11))});
            for (int i = 1; i < n; i++) frame_q.push_back(8'($urandom));
            run_frame();
            score_frame($sformatf("random%0d", f));
        end
    endtask

    task automatic test_reset_mid();
        open_frame();
        send_byte(8'h80);
        send_byte(8'h77);
        @(posedge sys_clk); #1;
        spi_rx_byte = 8'h99; spi_byte_rdy = 1'b1;
        repeat (2) @(posedge sys_clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (reg_q !== 64'h0 || busy !== 1'b0 || err !== 1'b0 || spi_tx_load !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_mid: got regs=%h busy=%b err=%b load=%b expected all zero",
                     reg_q, busy, err, spi_tx_load);
        end
        ss = 1'b0; spi_byte_rdy = 1'b0;
        for (int r = 0; r < 8; r++) mdl[r] = 8'h00;
        repeat (3) @(posedge sys_clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge sys_clk);
        frame_q = '{8'h05, 8'h00};
        run_frame();
        score_frame("after_reset");
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_wrap_read();
        test_error();
        test_race();
        test_latency();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
